// File: rtl/systolic_pkg.sv
// Shared configuration for the systolic sequencing controller: default sizes,
// run-length and step-counter width helpers, and the FSM state encoding.
package systolic_pkg;

  localparam int N_DEF      = 4;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic int run_len(input int n);
    return 3 * n - 1;
  endfunction

  function automatic int step_w(input int n);
    return $clog2(3 * n);
  endfunction

endpackage

// File: rtl/systolic_operand_bank.sv
// Two NxN operand banks (A = left operands, B = up operands) with one write
// port and N parallel skewed read ports indexed by the run step.
module systolic_operand_bank
  import systolic_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int IW     = $clog2(N),
  parameter int TW     = step_w(N)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic                  sel_i,
  input  logic [2*IW-1:0]       addr_i,
  input  logic [DATA_W-1:0]     data_i,
  input  logic [TW-1:0]         step_i,
  output logic [N*DATA_W-1:0]   left_o,
  output logic [N*DATA_W-1:0]   up_o
);

  logic [DATA_W-1:0] a_q [N][N];
  logic [DATA_W-1:0] b_q [N][N];
  logic [IW-1:0]     row;
  logic [IW-1:0]     col;

  assign row = addr_i[2*IW-1:IW];
  assign col = addr_i[IW-1:0];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          a_q[r][c] <= '0;
          b_q[r][c] <= '0;
        end
      end
    end else if (we_i && (int'(row) < N) && (int'(col) < N)) begin
      if (sel_i) begin
        b_q[row][col] <= data_i;
      end else begin
        a_q[row][col] <= data_i;
      end
    end
  end

  // Row r (and column c) is delayed by its own index so operands meet diagonally.
  always_comb begin
    int k;
    k      = 0;
    left_o = '0;
    up_o   = '0;
    for (int i = 0; i < N; i++) begin
      k = int'(step_i) - i;
      if ((k >= 0) && (k < N)) begin
        left_o[i*DATA_W +: DATA_W] = a_q[i][k[IW-1:0]];
        up_o[i*DATA_W +: DATA_W]   = b_q[k[IW-1:0]][i];
      end
    end
  end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Sequencer feeding an NxN systolic array: IDLE->CLEAR->RUN->DONE with skewed
// operand buses. Define SYSTOLIC_JOB_CNT_EN to add the 16-bit job_cnt_o output.
module systolic_seq_ctrl
  import systolic_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      cfg_we_i,
  input  logic                      cfg_sel_i,
  input  logic [2*$clog2(N)-1:0]    cfg_addr_i,
  input  logic [DATA_W-1:0]         cfg_data_i,
  input  logic                      start_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      arr_rst_no,
  output logic [N*DATA_W-1:0]       left_o,
  output logic [N*DATA_W-1:0]       up_o
`ifdef SYSTOLIC_JOB_CNT_EN
  ,output logic [15:0]              job_cnt_o
`endif
);

  localparam int IW      = $clog2(N);
  localparam int TW      = step_w(N);
  localparam int RUN_LEN = run_len(N);
  localparam logic [TW-1:0] T_LAST = TW'(RUN_LEN - 1);

  state_e                state_q, state_d;
  logic [TW-1:0]         t_q, t_d;
  logic                  start_q;
  logic                  busy_q, done_q, arr_rst_n_q;
  logic [N*DATA_W-1:0]   left_q, up_q;
  logic [N*DATA_W-1:0]   bank_left, bank_up;
  logic                  bank_we;

  assign bank_we = cfg_we_i && (state_q == ST_IDLE);

  systolic_operand_bank #(
    .N      (N),
    .DATA_W (DATA_W),
    .IW     (IW),
    .TW     (TW)
  ) u_bank (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .we_i   (bank_we),
    .sel_i  (cfg_sel_i),
    .addr_i (cfg_addr_i),
    .data_i (cfg_data_i),
    .step_i (t_d),
    .left_o (bank_left),
    .up_o   (bank_up)
  );

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    case (state_q)
      ST_IDLE: begin
        t_d = '0;
        if (start_q) begin
          state_d = ST_CLEAR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        state_d = ST_RUN;
        t_d     = '0;
      end
      ST_RUN: begin
        if (t_q == T_LAST) begin
          state_d = ST_DONE;
          t_d     = '0;
        end else begin
          t_d     = t_q + TW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        t_d     = '0;
      end
      default: begin
        state_d = ST_IDLE;
        t_d     = '0;
      end
    endcase
  end

  // Outputs are loaded from next-state values so each reflects the state it accompanies.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      t_q         <= '0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      arr_rst_n_q <= 1'b0;
      left_q      <= '0;
      up_q        <= '0;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      start_q     <= start_i && (state_q == ST_IDLE);
      busy_q      <= (state_d == ST_CLEAR) || (state_d == ST_RUN);
      done_q      <= (state_d == ST_DONE);
      arr_rst_n_q <= (state_d != ST_CLEAR);
      left_q      <= (state_d == ST_RUN) ? bank_left : '0;
      up_q        <= (state_d == ST_RUN) ? bank_up : '0;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign arr_rst_no = arr_rst_n_q;
  assign left_o     = left_q;
  assign up_o       = up_q;

`ifdef SYSTOLIC_JOB_CNT_EN
  logic [15:0] job_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      job_cnt_q <= 16'd0;
    end else if (state_q == ST_DONE) begin
      job_cnt_q <= job_cnt_q + 16'd1;
    end
  end

  assign job_cnt_o = job_cnt_q;
`endif

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Randomized self-checking bench for systolic_seq_ctrl against a matrix-level
// reference model; inputs change and outputs are sampled on the falling edge.
module tb_systolic_seq_ctrl;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              cfg_we_i;
  logic              cfg_sel_i;
  logic [2*IW-1:0]   cfg_addr_i;
  logic [DW-1:0]     cfg_data_i;
  logic              start_i;
  logic              busy_o;
  logic              done_o;
  logic              arr_rst_no;
  logic [N*DW-1:0]   left_o;
  logic [N*DW-1:0]   up_o;
`ifdef SYSTOLIC_JOB_CNT_EN
  logic [15:0]       job_cnt_o;
`endif

  systolic_seq_ctrl #(.N(N), .DATA_W(DW)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .cfg_we_i   (cfg_we_i),
    .cfg_sel_i  (cfg_sel_i),
    .cfg_addr_i (cfg_addr_i),
    .cfg_data_i (cfg_data_i),
    .start_i    (start_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .arr_rst_no (arr_rst_no),
    .left_o     (left_o),
    .up_o       (up_o)
`ifdef SYSTOLIC_JOB_CNT_EN
    ,.job_cnt_o (job_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] ma [N][N];
  logic [DW-1:0] mb [N][N];
  logic [DW-1:0] lh [N][3*N];
  logic [DW-1:0] uh [N][3*N];

  function automatic logic [DW-1:0] exp_left(input int r, input int t);
    int k;
    k = t - r;
    if (k >= 0 && k < N) return ma[r][k];
    return '0;
  endfunction

  function automatic logic [DW-1:0] exp_up(input int c, input int t);
    int k;
    k = t - c;
    if (k >= 0 && k < N) return mb[k][c];
    return '0;
  endfunction

  task automatic clear_model();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        ma[r][c] = '0;
        mb[r][c] = '0;
      end
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    clear_model();
    @(negedge clk_i);
  endtask

  task automatic wr(input bit sel, input int r, input int c, input logic [DW-1:0] d);
    cfg_we_i   = 1'b1;
    cfg_sel_i  = sel;
    cfg_addr_i = {2'(r), 2'(c)};
    cfg_data_i = d;
    @(negedge clk_i);
    cfg_we_i = 1'b0;
    if (sel) mb[r][c] = d;
    else     ma[r][c] = d;
  endtask

  // Full run: every cycle against the skew rules, then the array product from the bus history.
  task automatic run_and_check(input string tag);
    logic [DW-1:0] el, eu, acc, ex;
    int t;
    bit in_run;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    for (int k = 0; k <= 13; k++) begin
      t = k - 2;
      in_run = (k >= 2) && (k <= 12);
      checks++;
      if (busy_o !== ((k >= 1 && k <= 12) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL %s busy k=%0d got %b", tag, k, busy_o);
      end
      checks++;
      if (arr_rst_no !== ((k == 1) ? 1'b0 : 1'b1)) begin
        errors++; $display("FAIL %s arr_rst_no k=%0d got %b", tag, k, arr_rst_no);
      end
      checks++;
      if (done_o !== ((k == 13) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL %s done k=%0d got %b", tag, k, done_o);
      end
      for (int r = 0; r < N; r++) begin
        el = in_run ? exp_left(r, t) : '0;
        eu = in_run ? exp_up(r, t) : '0;
        checks++;
        if (left_o[r*DW +: DW] !== el) begin
          errors++; $display("FAIL %s left[%0d] k=%0d got %h want %h", tag, r, k, left_o[r*DW +: DW], el);
        end
        checks++;
        if (up_o[r*DW +: DW] !== eu) begin
          errors++; $display("FAIL %s up[%0d] k=%0d got %h want %h", tag, r, k, up_o[r*DW +: DW], eu);
        end
        if (in_run) begin
          lh[r][t] = left_o[r*DW +: DW];
          uh[r][t] = up_o[r*DW +: DW];
        end
      end
      @(negedge clk_i);
    end
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        acc = '0;
        for (int tt = 0; tt <= 3*N-2; tt++)
          if (tt - c >= 0 && tt - r >= 0) acc += lh[r][tt-c] * uh[c][tt-r];
        ex = '0;
        for (int k = 0; k < N; k++) ex += ma[r][k] * mb[k][c];
        checks++;
        if (acc !== ex) begin
          errors++; $display("FAIL %s product C[%0d][%0d] got %h want %h", tag, r, c, acc, ex);
        end
      end
  endtask

  task automatic wait_done(input string tag, output int k_done);
    k_done = -1;
    for (int k = 0; k < 20 && k_done < 0; k++) begin
      if (done_o === 1'b1) k_done = k;
      else @(negedge clk_i);
    end
    checks++;
    if (k_done < 0) begin
      errors++; $display("FAIL %s done timeout", tag);
    end
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    rst_i = 1'b1; cfg_we_i = 1'b0; cfg_sel_i = 1'b0; cfg_addr_i = '0;
    cfg_data_i = '0; start_i = 1'b0;
    clear_model();
    repeat (2) @(negedge clk_i);
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || arr_rst_no !== 1'b0) begin
      errors++; $display("FAIL reset ctrl got busy=%b done=%b arr=%b", busy_o, done_o, arr_rst_no);
    end
    checks++;
    if (left_o !== '0 || up_o !== '0) begin
      errors++; $display("FAIL reset buses got left=%h up=%h", left_o, up_o);
    end
`ifdef SYSTOLIC_JOB_CNT_EN
    checks++;
    if (job_cnt_o !== 16'd0) begin
      errors++; $display("FAIL reset job_cnt got %0d want 0", job_cnt_o);
    end
`endif
    rst_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (arr_rst_no !== 1'b1 || busy_o !== 1'b0) begin
      errors++; $display("FAIL reset release got arr=%b busy=%b", arr_rst_no, busy_o);
    end
  endtask

  task automatic test_identity();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        wr(1'b0, r, c, (r == c) ? 32'd1 : 32'd0);
        wr(1'b1, r, c, 32'(r*4 + c + 1));
      end
    run_and_check("identity");
  endtask

  task automatic test_skew();
    logic [DW-1:0] exp3 [N];
    exp3[0] = 32'h03; exp3[1] = 32'h12; exp3[2] = 32'h21; exp3[3] = 32'h30;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        wr(1'b0, r, c, 32'(16*r + c));
        wr(1'b1, r, c, 32'd0);
      end
    run_and_check("skew");
    for (int r = 0; r < N; r++) begin
      checks++;
      if (lh[r][3] !== exp3[r]) begin
        errors++; $display("FAIL skew t3 row%0d got %h want %h", r, lh[r][3], exp3[r]);
      end
      checks++;
      if (lh[r][7] !== 32'd0) begin
        errors++; $display("FAIL skew t7 row%0d got %h want 0", r, lh[r][7]);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 3; it++) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) begin
          wr(1'b0, r, c, 32'($urandom_range(0, 65535)));
          wr(1'b1, r, c, 32'($urandom_range(0, 65535)));
        end
      run_and_check("random");
    end
  endtask

  task automatic test_write_during_run();
    int kd;
    wr(1'b0, 0, 0, 32'h55);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (4) @(negedge clk_i);
    checks++;
    if (busy_o !== 1'b1) begin
      errors++; $display("FAIL wr_run not busy at t2 got %b", busy_o);
    end
    cfg_we_i = 1'b1; cfg_sel_i = 1'b0; cfg_addr_i = 4'h0; cfg_data_i = 32'hDEAD;
    @(negedge clk_i);
    cfg_we_i = 1'b0;
    wait_done("wr_run", kd);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (2) @(negedge clk_i);
    checks++;
    if (left_o[DW-1:0] !== 32'h55) begin
      errors++; $display("FAIL wr_run A00 got %h want 00000055", left_o[DW-1:0]);
    end
    wait_done("wr_run2", kd);
  endtask

  task automatic test_write_with_start();
    int kd;
    cfg_we_i = 1'b1; cfg_sel_i = 1'b1; cfg_addr_i = 4'hF; cfg_data_i = 32'd7;
    start_i = 1'b1;
    @(negedge clk_i);
    cfg_we_i = 1'b0; start_i = 1'b0;
    mb[3][3] = 32'd7;
    repeat (8) @(negedge clk_i);
    checks++;
    if (up_o[3*DW +: DW] !== 32'd7) begin
      errors++; $display("FAIL wr_start up3 t6 got %h want 7", up_o[3*DW +: DW]);
    end
    wait_done("wr_start", kd);
  endtask

  task automatic test_reset_mid_run();
    int kd;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (7) @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    checks++;
    if (arr_rst_no !== 1'b0 || busy_o !== 1'b0 || left_o !== '0 || up_o !== '0) begin
      errors++; $display("FAIL rst_mid got arr=%b busy=%b left=%h up=%h", arr_rst_no, busy_o, left_o, up_o);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      checks++;
      if (done_o !== 1'b0) begin
        errors++; $display("FAIL rst_mid done pulse got %b", done_o);
      end
    end
    rst_i = 1'b0;
    clear_model();
    @(negedge clk_i);
    checks++;
    if (arr_rst_no !== 1'b1 || busy_o !== 1'b0) begin
      errors++; $display("FAIL rst_mid release got arr=%b busy=%b", arr_rst_no, busy_o);
    end
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (5) @(negedge clk_i);
    checks++;
    if (left_o !== '0 || up_o !== '0) begin
      errors++; $display("FAIL rst_mid banks not cleared left=%h up=%h", left_o, up_o);
    end
    wait_done("rst_mid", kd);
    checks++;
    if (kd + 5 != 13) begin
      errors++; $display("FAIL rst_mid done latency got %0d want 13", kd + 5);
    end
  endtask

  task automatic test_back_to_back();
    int dk [$];
    do_reset();
    start_i = 1'b1;
    for (int k = 0; k < 60 && dk.size() < 3; k++) begin
      @(negedge clk_i);
      if (done_o === 1'b1) dk.push_back(k);
    end
    start_i = 1'b0;
    checks++;
    if (dk.size() != 3) begin
      errors++; $display("FAIL b2b pulses got %0d want 3", dk.size());
    end else begin
      checks++;
      if (dk[0] != 13 || dk[1] - dk[0] != 15 || dk[2] - dk[1] != 15) begin
        errors++; $display("FAIL b2b spacing got %0d %0d %0d want 13 28 43", dk[0], dk[1], dk[2]);
      end
    end
    @(negedge clk_i);
`ifdef SYSTOLIC_JOB_CNT_EN
    checks++;
    if (job_cnt_o !== 16'd3) begin
      errors++; $display("FAIL b2b job_cnt got %0d want 3", job_cnt_o);
    end
`endif
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_i);
      checks++;
      if (done_o !== 1'b0 || busy_o !== 1'b0) begin
        errors++; $display("FAIL b2b extra run done=%b busy=%b", done_o, busy_o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_skew();
    test_random();
    test_write_during_run();
    test_write_with_start();
    test_reset_mid_run();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
